// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-multiplexed sampling, whole-frame debounce,
// and a single-entry key register with ack/overrun handshake.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic [31:0] key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overrun_q, overrun_d;

  logic             tick, frame_done, accept;
  logic [2:0]       samp_cnt, acc_sum;
  logic [1:0]       samp_row;
  logic [3:0]       idx_new, f_key;
  logic             f_none, f_single;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [3:0] key_of(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h4;
      4'd2:  k = 4'h7;
      4'd3:  k = 4'h0;
      4'd4:  k = 4'h2;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h8;
      4'd7:  k = 4'hF;
      4'd8:  k = 4'h3;
      4'd9:  k = 4'h6;
      4'd10: k = 4'h9;
      4'd11: k = 4'hE;
      4'd12: k = 4'hA;
      4'd13: k = 4'hB;
      4'd14: k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick       = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_done = tick && (col_idx_q == 2'd3);

  // Frame accumulator: saturating count of low samples (2 means MULTI) plus
  // the position of the only low sample seen so far.
  always_comb begin
    samp_cnt = '0;
    samp_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row[r]) begin
        samp_cnt = samp_cnt + 3'd1;
        samp_row = 2'(r);
      end
    end
    acc_sum  = {1'b0, hits_q} + samp_cnt;
    idx_new  = (hits_q != 2'd0) ? idx_q : {col_idx_q, samp_row};
    f_none   = (acc_sum == 3'd0);
    f_single = (acc_sum == 3'd1);
    f_key    = key_of(idx_new);
  end

  always_comb begin
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    col_d     = col_q;
    col_idx_d = col_idx_q;
    hits_d    = hits_q;
    idx_d     = idx_q;
    if (tick) begin
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
      if (frame_done) begin
        hits_d = '0;
        idx_d  = '0;
      end else begin
        hits_d = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        idx_d  = idx_new;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (f_single) begin
            cand_d = f_key;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_FRAMES <= 1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (f_single && (f_key == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_W'(DEBOUNCE_FRAMES)) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (f_single) begin
            cand_d = f_key;
            cnt_d  = CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (f_none) begin
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE_FRAMES <= 1) ? IDLE : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (f_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_W'(DEBOUNCE_FRAMES)) begin
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // An accept wins over a same-cycle ack; overrun only when the old key was never taken.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept) begin
      key_code_d  = f_key;
      key_valid_d = 1'b1;
      overrun_d   = key_valid_q && !key_ack;
    end else if (key_valid_q && key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      col_q       <= 4'b1110;
      col_idx_q   <= '0;
      hits_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col       = col_q;
  assign key_code  = {28'd0, key_code_q};
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per column step (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical full-scan frames required to accept a press or a release.
REQ-003 SHALL have port clock, input, 1, meaning the single system clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port col, output, 4, meaning active-low column drive; exactly one bit is low at any time.
REQ-006 SHALL have port row, input, 4, meaning active-low row sense with external pull-ups.
REQ-007 SHALL have port key_code, output, 32, meaning the accepted key value 0-15 in bits [3:0], with bits [31:4] always 0.
REQ-008 SHALL have port key_valid, output, 1, meaning key_code holds an unconsumed key.
REQ-009 SHALL have port key_ack, input, 1, meaning the consumer has taken key_code.
REQ-010 SHALL have port overrun, output, 1, meaning an accepted key overwrote an unconsumed key.

Function
REQ-011 SHALL count clock cycles 0..SCAN_DIV-1; the cycle where the count equals SCAN_DIV-1 is the scan tick.
REQ-012 On each scan tick, SHALL sample row for the current column, then advance the column 0->1->2->3->0 (col 1110->1101->1011->0111->1110).
REQ-013 SHALL complete a frame on the tick that samples column 3; the frame result is one of: NONE (no row low in any column), SINGLE(idx) (exactly one low bit across all 16 samples, idx = col*4 + row bit), or MULTI.
REQ-014 SHALL map idx to key value using col0 rows0-3 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-015 SHALL implement the FSM states IDLE, PRESS_DB, HELD and RELEASE_DB, evaluated only at frame completion.
REQ-016 In IDLE: on SINGLE(k), SHALL latch candidate k, set cnt=1 and go to PRESS_DB; otherwise SHALL stay in IDLE.
REQ-017 In PRESS_DB: on SINGLE(k) equal to the candidate, SHALL increment cnt; on reaching DEBOUNCE_FRAMES, SHALL accept the key and go to HELD.
REQ-018 In PRESS_DB: on SINGLE with a different key, SHALL restart with the new candidate and cnt=1; on NONE or MULTI, SHALL return to IDLE.
REQ-019 In HELD: on NONE, SHALL set cnt=1 and go to RELEASE_DB; on SINGLE or MULTI, SHALL stay in HELD and report nothing further.
REQ-020 In RELEASE_DB: on NONE, SHALL increment cnt and go to IDLE on reaching DEBOUNCE_FRAMES; on SINGLE or MULTI, SHALL return to HELD.
REQ-021 With DEBOUNCE_FRAMES=1, SHALL accept on the first SINGLE frame and release on the first NONE frame.
REQ-022 On accept, in the same cycle, SHALL load key_code and set key_valid=1.
REQ-023 If key_valid was already 1 on accept and key_ack=0, SHALL overwrite key_code and set overrun=1.
REQ-024 When key_valid=1, key_ack=1 and there is no accept in that cycle, SHALL clear key_valid and overrun on the next edge.
REQ-025 Accept and key_ack in the same cycle: the new code SHALL load, key_valid SHALL stay 1 and overrun SHALL be 0.
REQ-026 key_ack while key_valid=0 SHALL have no effect.
REQ-027 key_code SHALL stay stable while key_valid=1, except on overwrite.
REQ-028 There SHALL be no combinational path from row to any output; all outputs SHALL be registered.

Reset
REQ-029 While reset_n=0, SHALL set col=1110, the divider to 0, FSM=IDLE, cnt=0, key_code=0, key_valid=0 and overrun=0 immediately, independent of clock.
REQ-030 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame; scanning SHALL restart at column 0 on the first edge after reset_n rises.

Verification (bench with SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-031 Hold row=1011 only while col=1101 for 2 frames -> key_valid rises at the end of frame 2 with key_code=8; key_ack -> key_valid=0 on the next cycle.
REQ-032 Key 5 pressed for 1 frame, then released -> key_valid stays 0 and the FSM returns to IDLE.
REQ-033 Keys 1 and 2 pressed together for 3 frames -> no key_valid; release both, then press D for 2 frames -> key_code=0xD.
REQ-034 Accept 3, no ack, release 2 frames, accept A -> key_code=0xA, key_valid=1, overrun=1; ack -> both clear.
REQ-035 key_ack high on the exact accept cycle of a second key -> key_valid=1, overrun=0, key_code=new key.
REQ-036 Assert reset_n=0 during PRESS_DB with col=1011 -> col=1110 and all outputs 0 asynchronously; after release, 8 clock cycles per column step are not required and the first tick occurs 4 cycles after reset_n rises.
